// File: rtl/lsram_port_arbiter_if.sv
// Requester-side bundle of the LSRAM port arbiter: command handshake plus
// tagged read-response return path.
interface lsram_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;

    // Client engines drive commands and sink responses.
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // The arbiter consumes commands and returns grants and responses.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/lsram_port_arbiter.sv
// Round-robin arbiter sharing one LSRAM port among NUM_REQ requesters.
// One command per cycle; read data is returned with a one-hot strobe naming
// the requester, RD_LATENCY+1 cycles after the command is accepted.
module lsram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    lsram_port_arbiter_if.slave   bus,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int PTR_W = $clog2(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("lsram_port_arbiter: NUM_REQ must be in 2..8");
        end
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_rd_latency
            $error("lsram_port_arbiter: RD_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      winner;
    logic                  found;
    logic                  accept;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    tag_pipe [RD_LATENCY+1];
    logic [NUM_REQ-1:0]    rsp_tag;

    // Search for the first valid requester starting at the priority pointer.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned idx;
            idx = k + 32'(ptr);
            if (idx >= NUM_REQ) begin
                idx = idx - 32'(NUM_REQ);
            end
            if (!found && bus.req_valid[PTR_W'(idx)]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    // A command offered during reset is never granted.
    always_comb begin
        accept = found & ~rst;
        grant  = '0;
        if (accept) begin
            grant[winner] = 1'b1;
        end
    end

    assign bus.req_ready = grant;

    // Advance the priority pointer past the requester just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Hold register presenting the accepted command to the LSRAM port.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            mem_we <= accept & bus.req_we[winner];
            if (accept) begin
                mem_addr <= bus.req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                mem_din  <= bus.req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Response tag shift register; stage RD_LATENCY lines up with mem_dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k <= RD_LATENCY; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            tag_pipe[0] <= grant & ~bus.req_we;
            for (int unsigned k = 1; k <= RD_LATENCY; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    // Responses are suppressed while reset is asserted so nothing leaks out.
    always_comb begin
        rsp_tag = rst ? '0 : tag_pipe[RD_LATENCY];
    end

    assign bus.rsp_valid = rsp_tag;
    assign bus.rsp_rdata = (|rsp_tag) ? mem_dout : '0;

endmodule

// File: tb/tb_lsram_port_arbiter.sv
// Bench for lsram_port_arbiter: two instances (RD_LATENCY 1 and 2) share the
// same command stream, each backed by its own behavioural LSRAM.
module tb_lsram_port_arbiter;

    localparam int NR = 4;
    localparam int DW = 18;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    lsram_port_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
    lsram_port_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

    logic          mem_we1, mem_we2;
    logic [AW-1:0] mem_addr1, mem_addr2;
    logic [DW-1:0] mem_din1, mem_din2, mem_dout1, mem_dout2;

    lsram_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_dout(mem_dout1)
    );

    lsram_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_din(mem_din2), .mem_dout(mem_dout2)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 10'h3FF) return 18'h00001;
        return 18'(a) * 18'd5 + 18'h00100;
    endfunction

    // Behavioural LSRAMs: registered read, optional output register for dut2.
    logic [DW-1:0]   m1 [1024];
    logic [DW-1:0]   m2 [1024];
    logic [1023:0]   m1_wr = '0;
    logic [1023:0]   m2_wr = '0;
    logic [DW-1:0]   m1_q, m2_q1, m2_q2;

    always @(posedge clk) begin
        if (mem_we1) begin
            m1[mem_addr1]    <= mem_din1;
            m1_wr[mem_addr1] <= 1'b1;
        end
        m1_q <= m1_wr[mem_addr1] ? m1[mem_addr1] : init_val(mem_addr1);
    end

    always @(posedge clk) begin
        if (mem_we2) begin
            m2[mem_addr2]    <= mem_din2;
            m2_wr[mem_addr2] <= 1'b1;
        end
        m2_q1 <= m2_wr[mem_addr2] ? m2[mem_addr2] : init_val(mem_addr2);
        m2_q2 <= m2_q1;
    end

    assign mem_dout1 = m1_q;
    assign mem_dout2 = m2_q2;

    typedef struct {
        logic          rst;
        logic [NR-1:0] valid;
        logic [NR-1:0] we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [NR-1:0] exp_ready;
    } vec_t;

    typedef struct {
        int            due;
        logic [NR-1:0] tag;
        logic [DW-1:0] data;
    } rsp_t;

    vec_t          vecs[$];
    rsp_t          q1[$];
    rsp_t          q2[$];
    logic [DW-1:0] shadow [int];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic          e_we   = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_din  = '0;
    logic          mem_known = 1'b0;

    function automatic vec_t mk(input logic r, input logic [NR-1:0] v, input logic [NR-1:0] w,
                                input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [NR-1:0] er);
        vec_t t;
        t.rst = r; t.valid = v; t.we = w; t.addr = a; t.wdata = d; t.exp_ready = er;
        return t;
    endfunction

    function automatic int onehot_idx(input logic [NR-1:0] oh);
        for (int i = 0; i < NR; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_rsp(input string name, inout rsp_t q[$],
                           input logic [NR-1:0] act_v, input logic [DW-1:0] act_d);
        rsp_t e;
        e.tag = '0;
        e.data = '0;
        if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
        chk({name, "_valid"}, 32'(act_v), 32'(e.tag));
        if (e.tag != '0) chk({name, "_rdata"}, 32'(act_d), 32'(e.data));
    endtask

    // One bus cycle: drive after the edge, check at the falling edge, then
    // advance the reference model.
    task automatic tick(input vec_t v);
        int w;
        rsp_t r;
        @(posedge clk);
        #1;
        cyc++;
        w = onehot_idx(v.exp_ready);
        rst = v.rst;
        // Winner sees the table address/data; every other requester differs.
        for (int i = 0; i < NR; i++) begin
            int a;
            int d;
            a = int'(v.addr) + 37 * (i - w);
            d = int'(v.wdata) + 4097 * (i - w);
            bus1.req_addr[i*AW +: AW]  = AW'(a);
            bus2.req_addr[i*AW +: AW]  = AW'(a);
            bus1.req_wdata[i*DW +: DW] = DW'(d);
            bus2.req_wdata[i*DW +: DW] = DW'(d);
        end
        bus1.req_valid = v.valid; bus2.req_valid = v.valid;
        bus1.req_we    = v.we;    bus2.req_we    = v.we;
        if (v.rst) begin
            q1.delete();
            q2.delete();
        end
        @(negedge clk);
        chk("req_ready1", 32'(bus1.req_ready), 32'(v.exp_ready));
        chk("req_ready2", 32'(bus2.req_ready), 32'(v.exp_ready));
        if (mem_known) begin
            chk("mem_we1", 32'(mem_we1), 32'(e_we));
            chk("mem_we2", 32'(mem_we2), 32'(e_we));
            chk("mem_addr1", 32'(mem_addr1), 32'(e_addr));
            chk("mem_din1", 32'(mem_din1), 32'(e_din));
            chk("mem_addr2", 32'(mem_addr2), 32'(e_addr));
            chk("mem_din2", 32'(mem_din2), 32'(e_din));
        end
        chk_rsp("rsp1", q1, bus1.rsp_valid, bus1.rsp_rdata);
        chk_rsp("rsp2", q2, bus2.rsp_valid, bus2.rsp_rdata);
        if (v.rst) begin
            mem_known = 1'b1;
            e_we = 1'b0; e_addr = '0; e_din = '0;
        end else if (v.exp_ready != '0) begin
            e_we   = v.we[w];
            e_addr = v.addr;
            e_din  = v.wdata;
            if (v.we[w]) begin
                shadow[int'(v.addr)] = v.wdata;
            end else begin
                r.tag  = v.exp_ready;
                r.data = shadow.exists(int'(v.addr)) ? shadow[int'(v.addr)] : init_val(v.addr);
                r.due  = cyc + 2;
                q1.push_back(r);
                r.due  = cyc + 3;
                q2.push_back(r);
            end
        end else begin
            e_we = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus1.req_valid = '0; bus2.req_valid = '0;
        bus1.req_we    = '0; bus2.req_we    = '0;
        bus1.req_addr  = '0; bus2.req_addr  = '0;
        bus1.req_wdata = '0; bus2.req_wdata = '0;

        // Reset with all requesters valid: nothing may be granted.
        vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 10'h000, 18'h00000, 4'b0000));
        repeat (5) vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 10'h000, 18'h00000, 4'b0000));
        // Requester 2 writes then reads back the same address.
        vecs.push_back(mk(1'b0, 4'b0100, 4'b0100, 10'h055, 18'h2A5A5, 4'b0100));
        vecs.push_back(mk(1'b0, 4'b0100, 4'b0000, 10'h055, 18'h00000, 4'b0100));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 10'h000, 18'h00000, 4'b0000));
        // Serve requester 3 so the pointer wraps back to 0.
        vecs.push_back(mk(1'b0, 4'b1000, 4'b0000, 10'h200, 18'h00000, 4'b1000));
        // All four reading continuously: strict rotation 0,1,2,3,0,1,2,3.
        for (int j = 0; j < 8; j++)
            vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, AW'(10'h100 + j), 18'h00000, 4'(1 << (j % 4))));
        // Pointer to 1, then two requesters 3 and 0 alternate across the wrap.
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0001, 10'h300, 18'h3AAAA, 4'b0001));
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 10'h300, 18'h00000, 4'b1000));
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 10'h301, 18'h00000, 4'b0001));
        vecs.push_back(mk(1'b0, 4'b1001, 4'b1001, 10'h302, 18'h12345, 4'b1000));
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 10'h302, 18'h00000, 4'b0001));
        // Two reads in flight, then reset with writes offered.
        vecs.push_back(mk(1'b0, 4'b0010, 4'b0000, 10'h110, 18'h00000, 4'b0010));
        vecs.push_back(mk(1'b0, 4'b0100, 4'b0000, 10'h111, 18'h00000, 4'b0100));
        vecs.push_back(mk(1'b1, 4'b1111, 4'b1111, 10'h0AA, 18'h15555, 4'b0000));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 10'h120, 18'h00000, 4'b0001));
        repeat (3) vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 10'h000, 18'h00000, 4'b0000));
        // Requester 3 reads the preloaded top word.
        vecs.push_back(mk(1'b0, 4'b1000, 4'b0000, 10'h3FF, 18'h00000, 4'b1000));
        // Read after reset-cycle write: the offered write must not have landed.
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 10'h0AA, 18'h00000, 4'b0001));

        foreach (vecs[k]) tick(vecs[k]);

        for (int d = 0; d < 10 && (q1.size() > 0 || q2.size() > 0); d++)
            tick(mk(1'b0, 4'b0000, 4'b0000, 10'h000, 18'h00000, 4'b0000));
        chk("drain_q1", 32'(q1.size()), 32'd0);
        chk("drain_q2", 32'(q2.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
